// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx : FIFO-buffered 8N1 UART transmitter
//
// Bytes written with a one-cycle tx_flag strobe go into a small FIFO. An FSM
// drains the FIFO one byte at a time and shifts each byte onto the serial
// line as start bit (0), eight data bits LSB first, and one stop bit (1).
// Consecutive queued bytes go out back-to-back with no idle gap.
//
// Parameters
//   BAUD_CNT_END : terminal count of the bit-period counter (bit = N+1 clocks)
//   FIFO_AW      : FIFO address width, depth = 2**FIFO_AW bytes
//
// Ports
//   sclk       : clock, all logic on the rising edge
//   s_rst_n    : asynchronous active-low reset
//   tx_data    : byte to transmit, sampled when tx_flag = 1
//   tx_flag    : one-cycle write strobe
//   rs232_tx   : registered serial line, idle high
//   tx_busy    : high while the FSM is not idle
//   fifo_full  : FIFO holds 2**FIFO_AW bytes
//   fifo_empty : FIFO holds no bytes
//   drop_flag  : one-cycle pulse after a write to a full FIFO was discarded
// ---------------------------------------------------------------------------
module uart_tx #(
  parameter int BAUD_CNT_END = 5207,
  parameter int FIFO_AW      = 4
) (
  input  logic       sclk,
  input  logic       s_rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_flag,
  output logic       rs232_tx,
  output logic       tx_busy,
  output logic       fifo_full,
  output logic       fifo_empty,
  output logic       drop_flag
);

  localparam int                 DEPTH     = 1 << FIFO_AW;
  // One spare bit keeps the width non-zero even for BAUD_CNT_END = 0.
  localparam int                 BCW       = $clog2(BAUD_CNT_END + 2);
  localparam logic [BCW-1:0]     BAUD_END  = BCW'(BAUD_CNT_END);
  localparam logic [FIFO_AW:0]   DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Declarations
  // -------------------------------------------------------------------------
  state_t             state;
  state_t             state_next;
  logic [BCW-1:0]     baud_cnt;
  logic [2:0]         bit_cnt;
  logic [7:0]         shift_reg;
  logic               line_next;
  logic               baud_end;
  logic               pop;
  logic               bit_adv;
  logic               push;
  logic               drop_next;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;

  // Status outputs come straight from registers; tx_flag never reaches them
  // combinationally.
  assign fifo_full  = (count == DEPTH_CNT);
  assign fifo_empty = (count == '0);
  assign tx_busy    = (state != IDLE);

  assign baud_end   = (baud_cnt == BAUD_END);

  // A full FIFO still accepts a write when the FSM pops on the same edge; an
  // empty FIFO can never pop, so a write to it is always stored.
  assign push       = tx_flag && (!fifo_full || pop);
  assign drop_next  = tx_flag && fifo_full && !pop;

  // -------------------------------------------------------------------------
  // FSM next-state and control decode
  // -------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    bit_adv    = 1'b0;
    line_next  = 1'b1;
    unique case (state)
      IDLE: begin
        line_next = 1'b1;
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        line_next = 1'b0;
        if (baud_end) state_next = DATA;
      end
      DATA: begin
        line_next = shift_reg[0];
        if (baud_end) begin
          bit_adv = 1'b1;
          if (bit_cnt == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        line_next = 1'b1;
        if (baud_end) begin
          // Chain straight into the next frame when more data is queued.
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM state register and bit timing
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The counter sits at zero in IDLE and clears on every terminal count, which
  // covers every state entry and every bit advance.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      baud_cnt <= '0;
    end else if (state == IDLE || baud_end) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  // Wraps 7 -> 0 on the last data bit, ready for the next frame.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      bit_cnt <= '0;
    end else if (bit_adv) begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      shift_reg <= '0;
    end else if (pop) begin
      shift_reg <= mem[rd_ptr];
    end else if (bit_adv) begin
      shift_reg <= {1'b0, shift_reg[7:1]};
    end
  end

  // Registered line: follows the current state one cycle later, so a write on
  // edge N pulls the line low from edge N+2.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      rs232_tx <= 1'b1;
    end else begin
      rs232_tx <= line_next;
    end
  end

  // -------------------------------------------------------------------------
  // FIFO
  // -------------------------------------------------------------------------
  // NOTE: the storage array has no reset; pointers and count define which
  // entries are valid, so stale contents are never read.
  always_ff @(posedge sclk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      drop_flag <= 1'b0;
    end else begin
      drop_flag <= drop_next;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx : directed self-checking bench for uart_tx
//
// Runs the transmitter with 4 clocks per bit and a 4-entry FIFO. Expected
// line levels and status flags are hand-derived from the write edge N:
// the line drops at N+2, each bit lasts 4 clocks, tx_busy is high from N+1
// for 40 clocks. A bench-side serial receiver decodes random bytes.
// Outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_uart_tx;

  localparam int BAUD_CNT_END = 3;
  localparam int FIFO_AW      = 2;

  logic       sclk = 1'b0;
  logic       s_rst_n = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_flag = 1'b0;
  logic       rs232_tx;
  logic       tx_busy;
  logic       fifo_full;
  logic       fifo_empty;
  logic       drop_flag;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx #(
    .BAUD_CNT_END(BAUD_CNT_END),
    .FIFO_AW     (FIFO_AW)
  ) dut (
    .sclk      (sclk),
    .s_rst_n   (s_rst_n),
    .tx_data   (tx_data),
    .tx_flag   (tx_flag),
    .rs232_tx  (rs232_tx),
    .tx_busy   (tx_busy),
    .fifo_full (fifo_full),
    .fifo_empty(fifo_empty),
    .drop_flag (drop_flag)
  );

  always #5 sclk = ~sclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  // Single write strobe; returns just after the write edge with tx_flag low.
  task automatic write_byte(input logic [7:0] d);
    tx_data = d;
    tx_flag = 1'b1;
    tick();
    tx_flag = 1'b0;
  endtask

  // Expected line level at cycle i of a frame (i = 0 is the first low cycle).
  function automatic logic frame_bit(input logic [7:0] d, input int i);
    int b;
    b = i / 4;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return d[b-1];
  endfunction

  // Called just after the edge where frame cycle 'skip' is visible; checks
  // the line on every remaining cycle and returns at cycle 0 of the next one.
  task automatic expect_frame(input logic [7:0] d, input int skip, input bit last, input string tag);
    for (int i = skip; i < 40; i++) begin
      check($sformatf("%s line[%0d]", tag, i), rs232_tx, frame_bit(d, i));
      if (i == 38) check($sformatf("%s busy[38]", tag), tx_busy, 1'b1);
      if (i == 39) check($sformatf("%s busy[39]", tag), tx_busy, last ? 1'b0 : 1'b1);
      tick();
    end
  endtask

  // Serial receiver: waits for a start bit, samples each bit mid-period.
  task automatic rx_byte(output logic [7:0] d, output bit ok);
    int wait_cnt;
    d  = '0;
    ok = 1'b0;
    wait_cnt = 0;
    while (rs232_tx !== 1'b0 && wait_cnt < 60) begin
      tick();
      wait_cnt++;
    end
    if (rs232_tx !== 1'b0) begin
      check("rx start timeout", 1'b1, 1'b0);
      return;
    end
    repeat (2) tick();
    for (int b = 0; b < 8; b++) begin
      repeat (4) tick();
      d[b] = rs232_tx;
    end
    repeat (4) tick();
    check("rx stop bit", rs232_tx, 1'b1);
    ok = 1'b1;
  endtask

  initial begin
    logic [7:0] bytes [6];
    logic [7:0] rx_d;
    logic [7:0] r;
    bit         ok;

    // ---------------- reset state ----------------
    #2 s_rst_n = 1'b0;
    #1;
    check("rst rs232_tx", rs232_tx, 1'b1);
    check("rst tx_busy", tx_busy, 1'b0);
    check("rst fifo_empty", fifo_empty, 1'b1);
    check("rst fifo_full", fifo_full, 1'b0);
    check("rst drop_flag", drop_flag, 1'b0);
    repeat (2) tick();
    s_rst_n = 1'b1;
    repeat (2) tick();
    check("idle line", rs232_tx, 1'b1);

    // ---------------- single frame 0xA5 ----------------
    write_byte(8'hA5);                       // now after edge N
    check("a5 line N", rs232_tx, 1'b1);
    check("a5 busy N", tx_busy, 1'b0);
    tick();                                  // after N+1
    check("a5 line N+1", rs232_tx, 1'b1);
    check("a5 busy N+1", tx_busy, 1'b1);
    tick();                                  // after N+2
    expect_frame(8'hA5, 0, 1'b1, "a5");
    check("a5 empty after", fifo_empty, 1'b1);
    repeat (3) tick();

    // ---------------- back-to-back 0x00, 0xFF ----------------
    write_byte(8'h00);                       // edge N
    write_byte(8'hFF);                       // edge N+1, coincides with pop
    check("b2b fifo count 1", fifo_empty, 1'b0);
    tick();                                  // after N+2
    expect_frame(8'h00, 0, 1'b0, "b2b0");
    expect_frame(8'hFF, 0, 1'b1, "b2b1");
    check("b2b empty after", fifo_empty, 1'b1);
    repeat (3) tick();

    // ---------------- overflow: 6 writes in 6 cycles ----------------
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h3C;
    bytes[3] = 8'h81; bytes[4] = 8'hE7; bytes[5] = 8'h5A;
    for (int k = 0; k < 6; k++) begin
      tx_data = bytes[k];
      tx_flag = 1'b1;
      tick();                                // after edge N+k
      if (k == 3) check("ovf full N+3", fifo_full, 1'b0);
      if (k == 4) check("ovf full N+4", fifo_full, 1'b1);
      if (k < 5)  check($sformatf("ovf drop N+%0d", k), drop_flag, 1'b0);
      if (k == 5) begin
        check("ovf drop N+5", drop_flag, 1'b1);
        check("ovf full N+5", fifo_full, 1'b1);
      end
    end
    tx_flag = 1'b0;
    tick();                                  // after N+6
    check("ovf drop N+6", drop_flag, 1'b0);
    check("ovf full N+6", fifo_full, 1'b1);
    expect_frame(bytes[0], 4, 1'b0, "ovf0");
    expect_frame(bytes[1], 0, 1'b0, "ovf1");
    expect_frame(bytes[2], 0, 1'b0, "ovf2");
    expect_frame(bytes[3], 0, 1'b0, "ovf3");
    expect_frame(bytes[4], 0, 1'b1, "ovf4");
    check("ovf no 6th frame", rs232_tx, 1'b1);
    check("ovf empty after", fifo_empty, 1'b1);
    repeat (3) tick();

    // ---------------- full FIFO, write on STOP-end pop ----------------
    bytes[0] = 8'h01; bytes[1] = 8'h80; bytes[2] = 8'h55;
    bytes[3] = 8'hAA; bytes[4] = 8'h0F; bytes[5] = 8'hC3;
    for (int k = 0; k < 5; k++) begin
      tx_data = bytes[k];
      tx_flag = 1'b1;
      tick();                                // after edge M+k
    end
    tx_flag = 1'b0;
    check("pw full M+4", fifo_full, 1'b1);
    repeat (36) tick();                      // after M+40
    check("pw full M+40", fifo_full, 1'b1);
    write_byte(bytes[5]);                    // edge M+41, STOP end pops
    check("pw drop M+41", drop_flag, 1'b0);
    check("pw full M+41", fifo_full, 1'b1);
    tick();                                  // after M+42
    check("pw drop M+42", drop_flag, 1'b0);
    expect_frame(bytes[1], 0, 1'b0, "pw1");
    expect_frame(bytes[2], 0, 1'b0, "pw2");
    expect_frame(bytes[3], 0, 1'b0, "pw3");
    expect_frame(bytes[4], 0, 1'b0, "pw4");
    expect_frame(bytes[5], 0, 1'b1, "pw5");
    check("pw empty after", fifo_empty, 1'b1);
    repeat (3) tick();

    // ---------------- reset mid-DATA with 3 bytes queued ----------------
    write_byte(8'h00);                       // edge R
    write_byte(8'h12);
    write_byte(8'h34);
    write_byte(8'h56);                       // edge R+3
    repeat (10) tick();                      // after R+13, inside DATA
    check("mr line low", rs232_tx, 1'b0);
    check("mr busy", tx_busy, 1'b1);
    check("mr not empty", fifo_empty, 1'b0);
    #2 s_rst_n = 1'b0;                       // between edges
    #1;
    check("mr rst line", rs232_tx, 1'b1);
    check("mr rst empty", fifo_empty, 1'b1);
    check("mr rst busy", tx_busy, 1'b0);
    check("mr rst full", fifo_full, 1'b0);
    repeat (2) tick();
    check("mr held line", rs232_tx, 1'b1);
    s_rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (rs232_tx !== 1'b1 || tx_busy !== 1'b0) begin
        check($sformatf("mr post line[%0d]", i), rs232_tx, 1'b1);
        check($sformatf("mr post busy[%0d]", i), tx_busy, 1'b0);
      end
    end
    check("mr post line", rs232_tx, 1'b1);
    check("mr post busy", tx_busy, 1'b0);
    check("mr post empty", fifo_empty, 1'b1);

    // ---------------- loopback through receiver, 256 random bytes ----------------
    for (int n = 0; n < 256; n++) begin
      r = 8'($urandom_range(0, 255));
      write_byte(r);
      rx_byte(rx_d, ok);
      if (ok) check($sformatf("rx byte %0d", n), rx_d, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter BAUD_CNT_END, default 5207: terminal count of the bit-period counter; one bit lasts BAUD_CNT_END+1 sclk cycles (9600 baud at 50 MHz).
REQ-002 The block SHALL have parameter FIFO_AW, default 4: FIFO address width; depth is 2**FIFO_AW bytes.
REQ-003 The block SHALL have port sclk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 The block SHALL have port s_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port tx_data, input, 8 bits: byte to transmit, sampled when tx_flag=1.
REQ-006 The block SHALL have port tx_flag, input, 1 bit: one-cycle write strobe.
REQ-007 The block SHALL have port rs232_tx, output, 1 bit: serial line, registered, idle high.
REQ-008 The block SHALL have port tx_busy, output, 1 bit: high while the FSM is not in IDLE.
REQ-009 The block SHALL have port fifo_full, output, 1 bit: FIFO count equals depth.
REQ-010 The block SHALL have port fifo_empty, output, 1 bit: FIFO count equals zero.
REQ-011 The block SHALL have port drop_flag, output, 1 bit: one-cycle pulse when a write is discarded.

Function
REQ-012 The frame SHALL be 8N1: start bit 0, data bits LSB first, one stop bit 1; 10 bit periods per frame.
REQ-013 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-014 IDLE -> START SHALL occur on the edge where the FIFO is non-empty; the head byte is popped into a shift register on that same edge.
REQ-015 START -> DATA, DATA -> STOP and bit advance inside DATA SHALL occur only on edges where baud_cnt==BAUD_CNT_END; baud_cnt SHALL reset to 0 on every state entry and bit advance.
REQ-016 DATA SHALL hold for exactly 8 bit periods, using a 3-bit bit counter that wraps 7->0 on DATA exit.
REQ-017 At the end of STOP: if the FIFO is non-empty, the next byte SHALL be popped and the FSM SHALL go directly to START (no idle gap); otherwise it SHALL go to IDLE.
REQ-018 Latency: a write with tx_flag=1 at edge N, with the FIFO empty and the FSM idle, SHALL drive rs232_tx low from edge N+2.
REQ-019 A write SHALL be accepted when the FIFO is not full, or when it is full and a pop occurs on the same edge; the count is then unchanged.
REQ-020 A write to a full FIFO with no simultaneous pop SHALL be discarded, and drop_flag SHALL be 1 for the following cycle only.
REQ-021 A write and a pop on the same edge with the FIFO empty is impossible: a pop requires non-empty, and the written byte is stored.
REQ-022 FIFO read and write pointers SHALL be FIFO_AW bits wide and wrap modulo depth; the count SHALL be FIFO_AW+1 bits.
REQ-023 fifo_full, fifo_empty and tx_busy SHALL be registered or derived from registers only, with no combinational path from tx_flag.

Reset
REQ-024 When s_rst_n=0, the block SHALL immediately force: rs232_tx=1, tx_busy=0, fifo_empty=1, fifo_full=0, drop_flag=0, FSM=IDLE, counters and pointers = 0.
REQ-025 A reset during a frame SHALL abort the frame, return the line high at once and discard all FIFO contents; no partial frame resumes after release.

Verification (BAUD_CNT_END=3, i.e. 4 cycles/bit, FIFO_AW=2)
REQ-026 The bench SHALL check: write 0xA5 at edge N -> rs232_tx low from N+2, then 1,0,1,0,0,1,0,1, then 1, each bit 4 cycles; tx_busy falls after 40 cycles.
REQ-027 The bench SHALL check: write 0x00, 0xFF on consecutive cycles -> two frames back-to-back, the second start bit immediately after the first stop bit, 80 cycles total.
REQ-028 The bench SHALL check: 6 writes in 6 consecutive cycles from idle -> first byte popped, 4 stored, fifo_full=1, the 6th dropped with one drop_flag pulse; 5 frames transmitted.
REQ-029 The bench SHALL check: FIFO full, write coinciding with the end of STOP (pop) -> write accepted, no drop_flag, fifo_full stays 1.
REQ-030 The bench SHALL check: assert s_rst_n=0 mid-DATA with 3 bytes queued -> rs232_tx=1 without waiting for an edge, fifo_empty=1; after release, the line stays high with no further frames.
REQ-031 The bench SHALL check: loop rs232_tx into uart_rx through 256 random bytes -> every byte received equals the byte sent.
